// File: rtl/seg_pkg.sv
// Segment encodings shared by the scan driver and its per-digit decoder.
// Bit order is a..g from MSB to LSB, 1 = lit.
package seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// One-digit hex to 7-segment decoder with a blanking override.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: one digit lit per refresh slot, with the
// display value swapped only at frame boundaries so a frame is never torn.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [SEG_W-1:0]        seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam bit INV = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] pend;
  logic                    pend_valid;
  logic                    slot_tick;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   lz;
  logic [3:0]              nib;
  logic                    lz_sel;
  logic                    digit_blank;
  logic [SEG_W-1:0]        seg_dec;
  logic [NUM_DIGITS-1:0]   an_dec;

  assign slot_tick = (cnt == CNT_LAST);
  assign frame_end = slot_tick && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_tick) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A load on the boundary cycle lands in pending and stays valid; the
  // display takes whatever was pending before it.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (frame_end && pend_valid) begin
        disp <= pend;
      end
      if (load) begin
        pend       <= value;
        pend_valid <= 1'b1;
      end else if (frame_end) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // lz[i] is set when nibble i and every nibble above it are zero.
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (disp[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (disp[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    nib    = 4'h0;
    lz_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib    = disp[4*i +: 4];
        lz_sel = lz[i];
      end
    end
  end

  assign digit_blank = blank_lz && lz_sel && (idx != '0);
  assign an_dec      = NUM_DIGITS'(1) << idx;

  seg_hex_decode u_dec (
    .nibble (nib),
    .blank  (digit_blank),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seg        <= SEG_BLANK ^ {SEG_W{INV}};
      an         <= {NUM_DIGITS{INV}};
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_dec ^ {SEG_W{INV}};
      an         <= an_dec ^ {NUM_DIGITS{INV}};
      frame_tick <= frame_end;
    end
  end

endmodule
